// File: rtl/fft4_frame_ctrl.sv
// fft4_frame_ctrl
// Streaming wrapper around the 4-point FFT core. Serial samples are packed
// into 4-sample frames, the core is launched with a one-cycle pulse, and the
// parallel result is captured and replayed as a valid/ready bin stream.
// Input and output buffers are independent so one frame can fill while the
// previous one drains. A watchdog drops a frame whose core never answers.
module fft4_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_real,
    input  logic signed [DATA_WIDTH-1:0] s_imag,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH+1:0] m_real,
    output logic signed [DATA_WIDTH+1:0] m_imag,
    output logic [1:0]                   m_index,
    output logic                         m_last,
    output logic                         core_en,
    output logic signed [DATA_WIDTH-1:0] core_in0_real,
    output logic signed [DATA_WIDTH-1:0] core_in0_imag,
    output logic signed [DATA_WIDTH-1:0] core_in1_real,
    output logic signed [DATA_WIDTH-1:0] core_in1_imag,
    output logic signed [DATA_WIDTH-1:0] core_in2_real,
    output logic signed [DATA_WIDTH-1:0] core_in2_imag,
    output logic signed [DATA_WIDTH-1:0] core_in3_real,
    output logic signed [DATA_WIDTH-1:0] core_in3_imag,
    input  logic                         core_valid,
    input  logic signed [DATA_WIDTH+1:0] core_out0_real,
    input  logic signed [DATA_WIDTH+1:0] core_out0_imag,
    input  logic signed [DATA_WIDTH+1:0] core_out1_real,
    input  logic signed [DATA_WIDTH+1:0] core_out1_imag,
    input  logic signed [DATA_WIDTH+1:0] core_out2_real,
    input  logic signed [DATA_WIDTH+1:0] core_out2_imag,
    input  logic signed [DATA_WIDTH+1:0] core_out3_real,
    input  logic signed [DATA_WIDTH+1:0] core_out3_imag,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [15:0]                  frame_cnt
);

    localparam int OW = DATA_WIDTH + 2;
    localparam int WW = $clog2(TIMEOUT + 1);
    // The watchdog register holds (count - 1), so the last allowed WAIT
    // cycle is the one where it reads TIMEOUT-1.
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [2:0]                  wp;
    logic [1:0]                  rp;
    logic signed [DATA_WIDTH-1:0] ibuf_re [4];
    logic signed [DATA_WIDTH-1:0] ibuf_im [4];
    logic signed [OW-1:0]         obuf_re [4];
    logic signed [OW-1:0]         obuf_im [4];
    logic                         obuf_full;
    logic [WW-1:0]                wdog;
    logic                         capture;
    logic                         expire;
    logic                         s_fire;
    logic                         m_fire;

    assign s_ready = (wp != 3'd4);
    assign s_fire  = s_valid && s_ready;
    assign m_fire  = obuf_full && m_ready;

    // Core FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Launch once a full frame is buffered and the output side has room.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (wp == 3'd4 && !obuf_full) state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_WAIT;
            ST_WAIT:   if (capture || expire) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; a core answer on the final watchdog cycle still counts.
    always_comb begin
        core_en = 1'b0;
        busy    = 1'b0;
        capture = 1'b0;
        expire  = 1'b0;
        unique case (state)
            ST_LAUNCH: begin
                core_en = 1'b1;
                busy    = 1'b1;
            end
            ST_WAIT: begin
                busy    = 1'b1;
                capture = core_valid;
                expire  = !core_valid && (wdog == WDOG_LAST);
            end
            default: ;
        endcase
    end

    // Input buffer fill; the frame is released on capture or on a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                ibuf_re[i] <= '0;
                ibuf_im[i] <= '0;
            end
        end else if (capture || expire) begin
            wp <= 3'd0;
        end else if (s_fire) begin
            ibuf_re[wp[1:0]] <= s_real;
            ibuf_im[wp[1:0]] <= s_imag;
            wp               <= wp + 3'd1;
        end
    end

    // Watchdog counts WAIT cycles since the launch pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wdog <= '0;
        else if (state == ST_LAUNCH) wdog <= '0;
        else if (state == ST_WAIT)   wdog <= wdog + 1'b1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      timeout_err <= 1'b0;
        else if (expire) timeout_err <= 1'b1;
    end

    // Output buffer capture and bin-by-bin drain with frame counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obuf_full <= 1'b0;
            rp        <= 2'd0;
            frame_cnt <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                obuf_re[i] <= '0;
                obuf_im[i] <= '0;
            end
        end else if (capture) begin
            obuf_re[0] <= core_out0_real;
            obuf_im[0] <= core_out0_imag;
            obuf_re[1] <= core_out1_real;
            obuf_im[1] <= core_out1_imag;
            obuf_re[2] <= core_out2_real;
            obuf_im[2] <= core_out2_imag;
            obuf_re[3] <= core_out3_real;
            obuf_im[3] <= core_out3_imag;
            obuf_full  <= 1'b1;
        end else if (m_fire) begin
            rp <= rp + 2'd1;
            if (rp == 2'd3) begin
                obuf_full <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign m_valid = obuf_full;
    assign m_real  = obuf_full ? obuf_re[rp] : '0;
    assign m_imag  = obuf_full ? obuf_im[rp] : '0;
    assign m_index = rp;
    assign m_last  = obuf_full && (rp == 2'd3);

    assign core_in0_real = ibuf_re[0];
    assign core_in0_imag = ibuf_im[0];
    assign core_in1_real = ibuf_re[1];
    assign core_in1_imag = ibuf_im[1];
    assign core_in2_real = ibuf_re[2];
    assign core_in2_imag = ibuf_im[2];
    assign core_in3_real = ibuf_re[3];
    assign core_in3_imag = ibuf_im[3];

endmodule

// File: tb/tb_fft4_frame_ctrl.sv
// tb_fft4_frame_ctrl
// Drives sample frames into the controller, emulates an fft4 core with a
// configurable latency (or a dead core), and checks the bin stream against
// a frame-level DFT model kept as a queue of expected bins.
module tb_fft4_frame_ctrl;

    localparam int DW  = 8;
    localparam int OW  = DW + 2;
    localparam int TMO = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_real;
    logic signed [DW-1:0] s_imag;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [OW-1:0] m_real;
    logic signed [OW-1:0] m_imag;
    logic [1:0]           m_index;
    logic                 m_last;
    logic                 core_en;
    logic signed [DW-1:0] ci_re [4];
    logic signed [DW-1:0] ci_im [4];
    logic                 core_valid;
    logic signed [OW-1:0] co_re [4];
    logic signed [OW-1:0] co_im [4];
    logic                 busy;
    logic                 timeout_err;
    logic [15:0]          frame_cnt;

    typedef struct {
        int re;
        int im;
        int idx;
    } bin_t;

    bin_t expq[$];
    bin_t obsq[$];
    int   drainq[$];
    int   enq[$];

    int passCount = 0;
    int checkCount = 0;
    int cyc = 0;
    int core_lat = 3;
    int en_count = 0;
    int exp_frames = 0;
    int exp_tmo = 0;
    int hs_cyc = 0;
    int fill = 0;
    int fr_re [4];
    int fr_im [4];
    bit stopToggle = 1'b0;
    bit randReady = 1'b0;

    fft4_frame_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .m_index(m_index), .m_last(m_last), .core_en(core_en),
        .core_in0_real(ci_re[0]), .core_in0_imag(ci_im[0]),
        .core_in1_real(ci_re[1]), .core_in1_imag(ci_im[1]),
        .core_in2_real(ci_re[2]), .core_in2_imag(ci_im[2]),
        .core_in3_real(ci_re[3]), .core_in3_imag(ci_im[3]),
        .core_valid(core_valid),
        .core_out0_real(co_re[0]), .core_out0_imag(co_im[0]),
        .core_out1_real(co_re[1]), .core_out1_imag(co_im[1]),
        .core_out2_real(co_re[2]), .core_out2_imag(co_im[2]),
        .core_out3_real(co_re[3]), .core_out3_imag(co_im[3]),
        .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Cycle counter, advanced on each rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // 4-point DFT of one frame: X[k] = sum x[n] * exp(-j*2*pi*k*n/4).
    function automatic int fftBin(input int r0, input int i0, input int r1, input int i1,
                                  input int r2, input int i2, input int r3, input int i3,
                                  input int k, input bit want_im);
        int wr[4];
        int wi[4];
        int xr[4];
        int xi[4];
        int accr;
        int acci;
        wr = '{1, 0, -1, 0};
        wi = '{0, -1, 0, 1};
        xr = '{r0, r1, r2, r3};
        xi = '{i0, i1, i2, i3};
        accr = 0;
        acci = 0;
        for (int n = 0; n < 4; n++) begin
            int p;
            p = (k * n) % 4;
            accr += xr[n] * wr[p] - xi[n] * wi[p];
            acci += xr[n] * wi[p] + xi[n] * wr[p];
        end
        return want_im ? acci : accr;
    endfunction

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checkCount++;
        if (obs == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Emulated fft4 core: answers core_lat cycles after en; 0 means dead.
    initial begin
        int rem;
        bit pend;
        int lr [4];
        int li [4];
        pend = 1'b0;
        rem = 0;
        core_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            co_re[k] = '0;
            co_im[k] = '0;
        end
        forever begin
            @(negedge clk);
            core_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    rem--;
                    if (rem == 0) begin
                        pend = 1'b0;
                        core_valid = 1'b1;
                        for (int k = 0; k < 4; k++) begin
                            co_re[k] = OW'(fftBin(lr[0], li[0], lr[1], li[1], lr[2], li[2], lr[3], li[3], k, 1'b0));
                            co_im[k] = OW'(fftBin(lr[0], li[0], lr[1], li[1], lr[2], li[2], lr[3], li[3], k, 1'b1));
                        end
                    end
                end
                if (core_en && core_lat > 0) begin
                    pend = 1'b1;
                    rem = core_lat;
                    for (int k = 0; k < 4; k++) begin
                        lr[k] = ci_re[k];
                        li[k] = ci_im[k];
                    end
                end
            end
        end
    end

    // Reference model and monitors, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (core_en) begin
                en_count++;
                enq.push_back(cyc);
            end
            if (s_valid && s_ready) begin
                fr_re[fill] = s_real;
                fr_im[fill] = s_imag;
                fill++;
                if (fill == 4) begin
                    fill = 0;
                    hs_cyc = cyc + 1;
                    if (core_lat > 0) begin
                        for (int k = 0; k < 4; k++) begin
                            bin_t b;
                            b.re  = fftBin(fr_re[0], fr_im[0], fr_re[1], fr_im[1], fr_re[2], fr_im[2], fr_re[3], fr_im[3], k, 1'b0);
                            b.im  = fftBin(fr_re[0], fr_im[0], fr_re[1], fr_im[1], fr_re[2], fr_im[2], fr_re[3], fr_im[3], k, 1'b1);
                            b.idx = k;
                            expq.push_back(b);
                        end
                    end else begin
                        exp_tmo = 1;
                    end
                end
            end
            if (m_valid) begin
                if (expq.size() == 0) begin
                    checkOutput("spurious m_valid", 1, 0);
                end else begin
                    checkOutput("bin real", m_real, expq[0].re);
                    checkOutput("bin imag", m_imag, expq[0].im);
                    checkOutput("bin index", m_index, expq[0].idx);
                    checkOutput("bin last", m_last, (expq[0].idx == 3) ? 1 : 0);
                    if (m_ready) begin
                        bin_t o;
                        o.re = m_real;
                        o.im = m_imag;
                        o.idx = m_index;
                        obsq.push_back(o);
                        if (expq[0].idx == 3) begin
                            exp_frames++;
                            drainq.push_back(cyc + 1);
                        end
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    // Offers one sample and returns just after the edge that accepted it.
    task automatic applyStimulus(input int re, input int im);
        int budget;
        s_valid = 1'b1;
        s_real  = DW'(re);
        s_imag  = DW'(im);
        budget  = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            budget++;
            if (budget > 300) begin
                checkOutput("s_ready wait", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pushRandomFrame(input bit gaps);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(int'($signed(DW'($urandom))), int'($signed(DW'($urandom))));
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while (expq.size() != 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("drain done", expq.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        fill = 0;
        expq.delete();
        exp_frames = 0;
        exp_tmo = 0;
        #1;
        checkOutput("rst s_ready", s_ready, 1);
        checkOutput("rst m_valid", m_valid, 0);
        checkOutput("rst m_real", m_real, 0);
        checkOutput("rst m_imag", m_imag, 0);
        checkOutput("rst m_index", m_index, 0);
        checkOutput("rst m_last", m_last, 0);
        checkOutput("rst core_en", core_en, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst timeout_err", timeout_err, 0);
        checkOutput("rst frame_cnt", frame_cnt, 0);
        checkOutput("rst core_in0_real", ci_re[0], 0);
        checkOutput("rst core_in1_imag", ci_im[1], 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Randomised or alternating m_ready while stopToggle is low.
    task automatic readyToggler();
        while (!stopToggle) begin
            @(posedge clk);
            #1;
            m_ready = randReady ? 1'($urandom) : !m_ready;
        end
        m_ready = 1'b1;
    endtask

    initial begin
        int bcyc;
        int budget;
        int eb;
        bit early;
        s_valid = 1'b0;
        s_real  = '0;
        s_imag  = '0;
        m_ready = 1'b1;

        // Power-on reset checks
        applyReset();

        // Known frame: (1,0),(2,0),(-1,0),(3,0)
        $display("[TB] known frame");
        core_lat = 3;
        obsq.delete();
        applyStimulus(1, 0);
        applyStimulus(2, 0);
        applyStimulus(-1, 0);
        applyStimulus(3, 0);
        s_valid = 1'b0;
        budget = 0;
        while (!m_valid && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("first bin latency", cyc - hs_cyc, 2 + core_lat);
        waitDrain();
        checkOutput("known bin count", obsq.size(), 4);
        if (obsq.size() == 4) begin
            checkOutput("known X0 re", obsq[0].re, 5);
            checkOutput("known X0 im", obsq[0].im, 0);
            checkOutput("known X1 re", obsq[1].re, 2);
            checkOutput("known X1 im", obsq[1].im, 1);
            checkOutput("known X2 re", obsq[2].re, -5);
            checkOutput("known X2 im", obsq[2].im, 0);
            checkOutput("known X3 re", obsq[3].re, 2);
            checkOutput("known X3 im", obsq[3].im, -1);
        end
        checkOutput("known en pulses", en_count, 1);
        checkOutput("known frame_cnt", frame_cnt, 1);

        // Three back-to-back frames
        $display("[TB] back-to-back frames");
        obsq.delete();
        for (int f = 0; f < 3; f++) pushRandomFrame(1'b0);
        s_valid = 1'b0;
        waitDrain();
        checkOutput("b2b bin count", obsq.size(), 12);
        checkOutput("b2b frame_cnt", frame_cnt, exp_frames);

        // Back-pressure: 8 samples with m_ready low for 40 cycles
        $display("[TB] back-pressure");
        m_ready = 1'b0;
        eb = en_count;
        pushRandomFrame(1'b0);
        pushRandomFrame(1'b0);
        s_valid = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkOutput("bp s_ready", s_ready, 0);
        checkOutput("bp en pulses", en_count - eb, 1);
        checkOutput("bp busy", busy, 0);
        checkOutput("bp m_valid", m_valid, 1);
        drainq.delete();
        enq.delete();
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        waitDrain();
        checkOutput("bp relaunch count", enq.size(), 1);
        if (enq.size() > 0 && drainq.size() > 0)
            checkOutput("bp relaunch gap", enq[0] - drainq[0], 1);
        checkOutput("bp frame_cnt", frame_cnt, exp_frames);

        // Core answers on the last watchdog cycle: normal capture
        $display("[TB] watchdog boundary");
        core_lat = TMO;
        pushRandomFrame(1'b0);
        s_valid = 1'b0;
        waitDrain();
        checkOutput("edge timeout_err", timeout_err, 0);
        checkOutput("edge frame_cnt", frame_cnt, exp_frames);

        // Dead core: frame dropped after TIMEOUT WAIT cycles
        $display("[TB] dead core");
        core_lat = 0;
        pushRandomFrame(1'b0);
        s_valid = 1'b0;
        budget = 0;
        while (!busy && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        bcyc = 0;
        early = 1'b0;
        while (busy && bcyc < 200) begin
            if (timeout_err) early = 1'b1;
            bcyc++;
            @(negedge clk);
        end
        checkOutput("dead busy cycles", bcyc, TMO + 1);
        checkOutput("dead early flag", early, 0);
        checkOutput("dead timeout_err", timeout_err, 1);
        checkOutput("dead s_ready", s_ready, 1);
        checkOutput("dead m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        core_lat = 2;
        pushRandomFrame(1'b0);
        s_valid = 1'b0;
        waitDrain();
        checkOutput("recover frame_cnt", frame_cnt, exp_frames);
        checkOutput("recover timeout_err", timeout_err, exp_tmo);

        // Reset after 2 samples, then mid-drain after bin 1
        $display("[TB] mid-operation reset");
        applyStimulus(7, -3);
        applyStimulus(-8, 4);
        s_valid = 1'b0;
        applyReset();
        m_ready = 1'b1;
        pushRandomFrame(1'b0);
        s_valid = 1'b0;
        budget = 0;
        while (expq.size() != 2 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("mid-drain reached", expq.size(), 2);
        applyReset();
        pushRandomFrame(1'b0);
        s_valid = 1'b0;
        waitDrain();
        checkOutput("post-reset frame_cnt", frame_cnt, 1);

        // Alternating m_ready
        $display("[TB] alternating m_ready");
        stopToggle = 1'b0;
        randReady = 1'b0;
        fork
            readyToggler();
        join_none
        pushRandomFrame(1'b0);
        pushRandomFrame(1'b0);
        s_valid = 1'b0;
        waitDrain();
        stopToggle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("alt frame_cnt", frame_cnt, exp_frames);

        // Random traffic with random back-pressure and latency
        $display("[TB] random traffic");
        core_lat = $urandom_range(1, TMO);
        stopToggle = 1'b0;
        randReady = 1'b1;
        fork
            readyToggler();
        join_none
        for (int f = 0; f < 6; f++) pushRandomFrame(1'b1);
        s_valid = 1'b0;
        waitDrain();
        stopToggle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rand frame_cnt", frame_cnt, exp_frames);
        checkOutput("rand timeout_err", timeout_err, exp_tmo);
        checkOutput("rand idle m_valid", m_valid, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
